// File: rtl/br_cdc_fifo_pop_upsizer_if.sv
// Handshake bundle for the pop-side upsizer: narrow beats in, wide flits out.
// The slave modport is the upsizer's view; master is the view of whatever feeds and drains it.
interface br_cdc_fifo_pop_upsizer_if #(
  parameter int Width = 8,
  parameter int Ratio = 4
);
  logic                     push_valid;
  logic                     push_ready;
  logic [Width-1:0]         push_data;
  logic                     push_last;
  logic                     pop_valid;
  logic                     pop_ready;
  logic [Width*Ratio-1:0]   pop_data;
  logic [Ratio-1:0]         pop_mask;
  logic                     pop_last;

  modport slave (
    input  push_valid, push_data, push_last, pop_ready,
    output push_ready, pop_valid, pop_data, pop_mask, pop_last
  );

  modport master (
    output push_valid, push_data, push_last, pop_ready,
    input  push_ready, pop_valid, pop_data, pop_mask, pop_last
  );
endinterface

// File: rtl/br_cdc_fifo_pop_upsizer_out_reg.sv
// Wide-flit output register. A load may coincide with a drain, which keeps flits back-to-back.
// Payload only changes on a load, so it never toggles while pop_valid is low.
module br_cdc_fifo_pop_upsizer_out_reg #(
  parameter int Width = 8,
  parameter int Ratio = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [Width*Ratio-1:0] load_data,
  input  logic [Ratio-1:0]       load_mask,
  input  logic                   load_last,
  input  logic                   pop_ready,
  output logic                   pop_valid,
  output logic [Width*Ratio-1:0] pop_data,
  output logic [Ratio-1:0]       pop_mask,
  output logic                   pop_last,
  output logic                   can_load
);
  assign can_load = !pop_valid || pop_ready;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_valid <= 1'b0;
      pop_data  <= '0;
      pop_mask  <= '0;
      pop_last  <= 1'b0;
    end else if (load) begin
      pop_valid <= 1'b1;
      pop_data  <= load_data;
      pop_mask  <= load_mask;
      pop_last  <= load_last;
    end else if (pop_ready) begin
      pop_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/br_cdc_fifo_pop_upsizer.sv
// Pop-side width upsizer: packs Ratio narrow beats (or fewer, when closed by push_last)
// into one registered wide flit with a contiguous lane mask.
module br_cdc_fifo_pop_upsizer #(
  parameter int Width = 8,
  parameter int Ratio = 4,
  parameter bit EnableAssertPushValidStability = 1'b1,
  parameter bit EnableAssertFinalNotValid = 1'b1
) (
  input  logic clk,
  input  logic rst,
  br_cdc_fifo_pop_upsizer_if.slave up,
  output logic busy
);
  localparam int NumAsmLanes = Ratio - 1;
  localparam int CntWidth    = $clog2(Ratio);

  typedef logic [CntWidth-1:0] lane_idx_t;

  localparam lane_idx_t LastIdx = lane_idx_t'(Ratio - 1);

  lane_idx_t                             cnt;
  logic [NumAsmLanes-1:0][Width-1:0]     asm_lanes;
  logic [Ratio-1:0][Width-1:0]           flit_data;
  logic [Ratio-1:0]                      flit_mask;
  logic                                  completing;
  logic                                  accept;
  logic                                  load;
  logic                                  can_load;

  // Only a completing beat needs the output register, so only it can be stalled.
  assign completing    = (cnt == LastIdx) || up.push_last;
  assign up.push_ready = !completing || can_load;
  assign accept        = up.push_valid && up.push_ready;
  assign load          = accept && completing;
  assign busy          = (cnt != '0) || up.pop_valid;

  // NOTE: every combinational output gets a default before any conditional
  // assignment; otherwise a missed branch infers a latch.
  always_comb begin
    flit_data = '0;
    flit_mask = '0;
    for (int k = 0; k < NumAsmLanes; k++) begin
      if (lane_idx_t'(k) < cnt) begin
        flit_data[k] = asm_lanes[k];
        flit_mask[k] = 1'b1;
      end
    end
    for (int k = 0; k < Ratio; k++) begin
      if (lane_idx_t'(k) == cnt) begin
        flit_data[k] = up.push_data;
        flit_mask[k] = 1'b1;
      end
    end
  end

  // NOTE: the assembly lanes are reset even though the mask already hides stale
  // lanes; cleared storage keeps the first flit after reset deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      asm_lanes <= '0;
    end else if (accept) begin
      if (completing) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + lane_idx_t'(1);
        for (int k = 0; k < NumAsmLanes; k++) begin
          if (lane_idx_t'(k) == cnt) asm_lanes[k] <= up.push_data;
        end
      end
    end
  end

  br_cdc_fifo_pop_upsizer_out_reg #(
    .Width (Width),
    .Ratio (Ratio)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (flit_data),
    .load_mask (flit_mask),
    .load_last (up.push_last),
    .pop_ready (up.pop_ready),
    .pop_valid (up.pop_valid),
    .pop_data  (up.pop_data),
    .pop_mask  (up.pop_mask),
    .pop_last  (up.pop_last),
    .can_load  (can_load)
  );

`ifndef SYNTHESIS
  logic [Ratio-1:0] mask_plus_one;
  assign mask_plus_one = up.pop_mask + {{(Ratio-1){1'b0}}, 1'b1};

  if (EnableAssertPushValidStability) begin : g_push_stable
    a_push_stable: assert property (@(posedge clk) disable iff (rst)
      up.push_valid && !up.push_ready |=> up.push_valid && $stable(up.push_data) && $stable(up.push_last));
  end

  a_pop_stable: assert property (@(posedge clk) disable iff (rst)
    up.pop_valid && !up.pop_ready |=> up.pop_valid && $stable(up.pop_data) && $stable(up.pop_mask)
      && $stable(up.pop_last));

  a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt <= LastIdx);

  // A contiguous-from-zero mask plus one has no bits in common with the mask.
  a_mask_shape: assert property (@(posedge clk) disable iff (rst)
    up.pop_valid |-> (up.pop_mask != '0) && ((up.pop_mask & mask_plus_one) == '0));

  c_partial_flit: cover property (@(posedge clk) disable iff (rst) up.pop_valid && !up.pop_mask[Ratio-1]);
  c_back_to_back: cover property (@(posedge clk) disable iff (rst) up.pop_valid && up.pop_ready && load);
  c_stalled_beat: cover property (@(posedge clk) disable iff (rst) up.push_valid && completing && !can_load);

  final begin
    if (EnableAssertFinalNotValid) begin
      a_final_idle: assert (!up.pop_valid && cnt == '0);
    end
  end
`endif
endmodule

// File: tb/tb_br_cdc_fifo_pop_upsizer.sv
// Self-checking bench for br_cdc_fifo_pop_upsizer: directed scenarios then random traffic,
// scored every cycle against a queue-based flit model.
module tb_br_cdc_fifo_pop_upsizer;
  localparam int Width = 8;
  localparam int Ratio = 4;
  localparam int FlitW = Width * Ratio;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   pop_mode = 1;  // 0: hold pop_ready low, 1: high, 2: random

  br_cdc_fifo_pop_upsizer_if #(.Width(Width), .Ratio(Ratio)) bus ();

  br_cdc_fifo_pop_upsizer #(
    .Width                          (Width),
    .Ratio                          (Ratio),
    .EnableAssertPushValidStability (1'b1),
    .EnableAssertFinalNotValid      (1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .up   (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: beats collected in a queue, one output slot for the flit on offer.
  logic [Width-1:0] partial[$];
  logic             m_valid;
  logic [FlitW-1:0] m_data;
  logic [Ratio-1:0] m_mask;
  logic             m_last;
  logic             exp_ready;
  logic [FlitW-1:0] acc;

  always @(negedge clk) begin
    if (rst) begin
      partial.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_mask  = '0;
      m_last  = 1'b0;
      check("rst_pop_valid",  64'(bus.pop_valid),  64'(0));
      check("rst_pop_data",   64'(bus.pop_data),   64'(0));
      check("rst_pop_mask",   64'(bus.pop_mask),   64'(0));
      check("rst_busy",       64'(busy),           64'(0));
      check("rst_push_ready", 64'(bus.push_ready), 64'(1));
    end else begin
      check("pop_valid", 64'(bus.pop_valid), 64'(m_valid));
      check("pop_data",  64'(bus.pop_data),  64'(m_data));
      check("pop_mask",  64'(bus.pop_mask),  64'(m_mask));
      check("pop_last",  64'(bus.pop_last),  64'(m_last));
      check("busy",      64'(busy),          64'((partial.size() != 0) || m_valid));
      exp_ready = ((partial.size() < Ratio - 1) && !bus.push_last) || !m_valid || bus.pop_ready;
      check("push_ready", 64'(bus.push_ready), 64'(exp_ready));
      if (bus.push_valid && exp_ready) begin
        partial.push_back(bus.push_data);
        if (partial.size() == Ratio || bus.push_last) begin
          acc = '0;
          foreach (partial[k]) acc = acc | (FlitW'(partial[k]) << (k * Width));
          m_data  = acc;
          m_mask  = Ratio'((1 << partial.size()) - 1);
          m_last  = bus.push_last;
          m_valid = 1'b1;
          partial.delete();
        end else if (bus.pop_ready) begin
          m_valid = 1'b0;
        end
      end else if (bus.pop_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin
    bus.pop_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (pop_mode)
        0:       bus.pop_ready = 1'b0;
        1:       bus.pop_ready = 1'b1;
        default: bus.pop_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Entered and left at posedge+1; holds the beat until it is accepted.
  task automatic send_beat(input logic [Width-1:0] d, input logic l);
    bit done;
    done = 1'b0;
    bus.push_valid = 1'b1;
    bus.push_data  = d;
    bus.push_last  = l;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.push_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    check("beat_accepted", 64'(done), 64'(1));
  endtask

  task automatic idle(input int n);
    bus.push_valid = 1'b0;
    bus.push_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.push_valid = 1'b0;
    bus.push_data  = '0;
    bus.push_last  = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Full flit with no backpressure.
    send_beat(8'h11, 1'b0); send_beat(8'h22, 1'b0); send_beat(8'h33, 1'b0); send_beat(8'h44, 1'b0);
    idle(2);

    // Partial flit closed by push_last, then the next beat starts at lane 0.
    send_beat(8'hAA, 1'b0); send_beat(8'hBB, 1'b1);
    send_beat(8'hCC, 1'b0); send_beat(8'hDD, 1'b0); send_beat(8'hEE, 1'b0); send_beat(8'hFF, 1'b0);
    idle(2);

    // Completing beat stalled behind a held flit.
    pop_mode = 0;
    idle(2);
    send_beat(8'h11, 1'b0); send_beat(8'h22, 1'b0); send_beat(8'h33, 1'b0); send_beat(8'h44, 1'b0);
    send_beat(8'h55, 1'b0); send_beat(8'h66, 1'b0); send_beat(8'h77, 1'b0);
    bus.push_valid = 1'b1;
    bus.push_data  = 8'h88;
    bus.push_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_push_ready", 64'(bus.push_ready), 64'(0));
      check("stall_pop_data",   64'(bus.pop_data),   64'(32'h44332211));
      @(posedge clk);
      #1;
    end
    pop_mode = 1;
    send_beat(8'h88, 1'b0);
    idle(3);

    // Sixteen continuous beats: four back-to-back flits.
    for (int i = 0; i < 16; i++) send_beat(Width'(i), 1'b0);
    idle(3);

    // Asynchronous reset discards a partial flit.
    send_beat(8'h01, 1'b0); send_beat(8'h02, 1'b0);
    bus.push_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_pop_valid",  64'(bus.pop_valid),  64'(0));
    check("async_rst_busy",       64'(busy),           64'(0));
    check("async_rst_push_ready", 64'(bus.push_ready), 64'(1));
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    send_beat(8'h10, 1'b0); send_beat(8'h11, 1'b0); send_beat(8'h12, 1'b0); send_beat(8'h13, 1'b0);
    idle(3);

    // Single-beat flit.
    send_beat(8'h5A, 1'b1);
    idle(3);

    // Random traffic, random backpressure, random gaps.
    pop_mode = 2;
    repeat (300) begin
      send_beat(Width'($urandom), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    send_beat(Width'($urandom), 1'b1);
    pop_mode = 1;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
